// File: rtl/cache_mem_ctrl_if.sv
// Word-addressed main-memory request/acknowledge bus between cache_mem_ctrl
// (master) and the memory (slave).
interface cache_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Miss-service controller: optional dirty-victim write-back, then word fetch and
// one-cycle fill pulse, with bounded memory wait and saturating event counters.
module cache_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             miss_req,
  input  logic             wb_req,
  input  logic [31:0]      miss_addr,
  input  logic [31:0]      wb_addr,
  input  logic [31:0]      wb_data,
  output logic [31:0]      fill_data,
  output logic             fill_valid,
  output logic             fill_err,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  cache_mem_ctrl_if.master mem
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [31:0]   miss_lat;
  logic [TW-1:0] timer;
  logic          expired;

  // Last permitted wait cycle passed without an ack; an ack on that same edge wins.
  always_comb begin
    expired = 1'b0;
    if (TIMEOUT_CYCLES != 0)
      expired = (timer == TLAST);
  end

  // The victim address/data are latched straight into mem_addr/mem_wdata,
  // which hold steady for the whole write-back phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      miss_lat      <= '0;
      timer         <= '0;
      fill_data     <= '0;
      fill_valid    <= 1'b0;
      fill_err      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      miss_cnt      <= '0;
      wb_cnt        <= '0;
    end else begin
      fill_valid <= 1'b0;
      fill_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss_req) begin
            miss_lat    <= miss_addr & 32'hFFFF_FFFC;
            timer       <= '0;
            busy        <= 1'b1;
            mem.mem_req <= 1'b1;
            if (miss_cnt != '1)
              miss_cnt <= miss_cnt + 1'b1;
            if (wb_req) begin
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= wb_addr & 32'hFFFF_FFFC;
              mem.mem_wdata <= wb_data;
              state         <= S_WB;
            end else begin
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= miss_addr & 32'hFFFF_FFFC;
              state        <= S_RD;
            end
          end
        end
        S_WB: begin
          if (mem.mem_ack) begin
            if (wb_cnt != '1)
              wb_cnt <= wb_cnt + 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= miss_lat;
            timer        <= '0;
            state        <= S_RD;
          end else if (expired) begin
            err         <= 1'b1;
            fill_err    <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= S_ABORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RD: begin
          if (mem.mem_ack) begin
            fill_data   <= mem.mem_rdata;
            fill_valid  <= 1'b1;
            mem.mem_req <= 1'b0;
            state       <= S_FILL;
          end else if (expired) begin
            err         <= 1'b1;
            fill_err    <= 1'b1;
            mem.mem_req <= 1'b0;
            state       <= S_ABORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FILL, S_ABORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy        <= 1'b0;
          mem.mem_req <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Randomized self-checking bench for cache_mem_ctrl: a 2-bit-counter instance and a
// 16-bit-counter instance share stimulus; expectations come from a transaction model.
module tb_cache_mem_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req, wb_req;
  logic [31:0] miss_addr, wb_addr, wb_data;

  logic [31:0] fill_data, fill_data_b;
  logic        fill_valid, fill_err, busy, err;
  logic        fill_valid_b, fill_err_b, busy_b, err_b;
  logic [1:0]  miss_cnt, wb_cnt;
  logic [15:0] miss_cnt_b, wb_cnt_b;

  cache_mem_ctrl_if mbus();
  cache_mem_ctrl_if mbus_b();
  assign mbus_b.mem_ack   = mbus.mem_ack;
  assign mbus_b.mem_rdata = mbus.mem_rdata;

  cache_mem_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .wb_req(wb_req),
    .miss_addr(miss_addr), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_data(fill_data), .fill_valid(fill_valid), .fill_err(fill_err),
    .busy(busy), .err(err), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt), .mem(mbus)
  );

  cache_mem_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .miss_req(miss_req), .wb_req(wb_req),
    .miss_addr(miss_addr), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_data(fill_data_b), .fill_valid(fill_valid_b), .fill_err(fill_err_b),
    .busy(busy_b), .err(err_b), .miss_cnt(miss_cnt_b), .wb_cnt(wb_cnt_b), .mem(mbus_b)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          miss_total = 0;
  int          wb_total = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_fill = '0;

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    miss_total = 0;
    wb_total   = 0;
    exp_err    = 1'b0;
    exp_fill   = '0;
  endtask

  task automatic drive_noise(input bit noisy);
    if (noisy) begin
      miss_req  = 1'($urandom);
      wb_req    = 1'($urandom);
      miss_addr = $urandom;
      wb_addr   = $urandom;
      wb_data   = $urandom;
    end else begin
      miss_req = 1'b0;
    end
  endtask

  // One miss transaction; dwb/drd = wait cycles before ack (>= T means never).
  task automatic run_miss(input bit wb, input logic [31:0] maddr, input logic [31:0] waddr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int dwb, input int drd, input bit noisy);
    bit acked;
    @(negedge clk);
    miss_req = 1'b1; wb_req = wb; miss_addr = maddr; wb_addr = waddr; wb_data = wdata;
    mbus.mem_ack = 1'b0;
    miss_total++;
    acked = 1'b1;
    if (wb) begin
      acked = 1'b0;
      for (int k = 0; k < T; k++) begin
        @(negedge clk);
        checks++;
        if ({mbus.mem_req, mbus.mem_we, busy, fill_valid} !== 4'b1110 ||
            mbus.mem_addr !== (waddr & 32'hFFFF_FFFC) || mbus.mem_wdata !== wdata) begin
          errors++;
          $display("FAIL wb_phase cyc=%0d req/we/busy/fv=%b addr=%h wdata=%h required 1110 %h %h",
                   k, {mbus.mem_req, mbus.mem_we, busy, fill_valid}, mbus.mem_addr,
                   mbus.mem_wdata, waddr & 32'hFFFF_FFFC, wdata);
        end
        drive_noise(noisy);
        mbus.mem_ack   = (k == dwb);
        mbus.mem_rdata = $urandom;
        if (k == dwb) begin
          acked = 1'b1;
          break;
        end
      end
      if (acked) wb_total++;
    end
    if (acked) begin
      acked = 1'b0;
      for (int k = 0; k < T; k++) begin
        @(negedge clk);
        checks++;
        if ({mbus.mem_req, mbus.mem_we, busy, fill_valid} !== 4'b1010 ||
            mbus.mem_addr !== (maddr & 32'hFFFF_FFFC)) begin
          errors++;
          $display("FAIL rd_phase cyc=%0d req/we/busy/fv=%b addr=%h required 1010 %h",
                   k, {mbus.mem_req, mbus.mem_we, busy, fill_valid}, mbus.mem_addr,
                   maddr & 32'hFFFF_FFFC);
        end
        drive_noise(noisy);
        mbus.mem_ack   = (k == drd);
        mbus.mem_rdata = (k == drd) ? rdata : $urandom;
        if (k == drd) begin
          acked = 1'b1;
          break;
        end
      end
    end
    @(negedge clk);
    if (acked) exp_fill = rdata;
    else exp_err = 1'b1;
    checks++;
    if ({mbus.mem_req, busy, fill_valid, fill_err, err} !== {1'b0, 1'b1, acked, !acked, exp_err} ||
        fill_data !== exp_fill) begin
      errors++;
      $display("FAIL end_phase req/busy/fv/ferr/err=%b fill_data=%h required %b %h",
               {mbus.mem_req, busy, fill_valid, fill_err, err}, fill_data,
               {1'b0, 1'b1, acked, !acked, exp_err}, exp_fill);
    end
    drive_noise(noisy);
    mbus.mem_ack   = noisy ? 1'($urandom) : 1'b0;
    mbus.mem_rdata = $urandom;
    @(negedge clk);
    miss_req = 1'b0;
    mbus.mem_ack = 1'b0;
    checks++;
    if ({busy, fill_valid, fill_err, mbus.mem_req, err} !== {4'b0, exp_err} ||
        fill_data !== exp_fill) begin
      errors++;
      $display("FAIL idle_return busy/fv/ferr/req/err=%b fill_data=%h required %b %h",
               {busy, fill_valid, fill_err, mbus.mem_req, err}, fill_data, {4'b0, exp_err}, exp_fill);
    end
    checks++;
    if (miss_cnt !== 2'(sat(miss_total, 2)) || wb_cnt !== 2'(sat(wb_total, 2)) ||
        miss_cnt_b !== 16'(sat(miss_total, 16)) || wb_cnt_b !== 16'(sat(wb_total, 16))) begin
      errors++;
      $display("FAIL counters miss/wb=%0d/%0d wide=%0d/%0d required %0d/%0d wide=%0d/%0d",
               miss_cnt, wb_cnt, miss_cnt_b, wb_cnt_b, sat(miss_total, 2), sat(wb_total, 2),
               sat(miss_total, 16), sat(wb_total, 16));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({fill_data, fill_valid, fill_err, busy, err, mbus.mem_req, mbus.mem_we,
         mbus.mem_addr, mbus.mem_wdata, miss_cnt, wb_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values fill_data=%h fv=%b ferr=%b busy=%b err=%b req=%b we=%b addr=%h wdata=%h cnt=%0d/%0d required all zero",
               fill_data, fill_valid, fill_err, busy, err, mbus.mem_req, mbus.mem_we,
               mbus.mem_addr, mbus.mem_wdata, miss_cnt, wb_cnt);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clean_miss();
    run_miss(1'b0, 32'h0000_1006, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0);
    checks++;
    if (miss_cnt !== 2'd1 || wb_cnt !== 2'd0 || fill_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL clean_miss miss/wb=%0d/%0d fill_data=%h required 1/0 deadbeef",
               miss_cnt, wb_cnt, fill_data);
    end
  endtask

  task automatic test_dirty_miss();
    run_miss(1'b1, 32'h0000_3010, 32'h0000_2008, 32'h1234_5678, $urandom, 1, 1, 1'b0);
    run_miss(1'b1, $urandom, $urandom, $urandom, $urandom, 0, 0, 1'b0);
    checks++;
    if (wb_cnt !== 2'd2) begin
      errors++;
      $display("FAIL dirty_miss wb_cnt=%0d required 2", wb_cnt);
    end
  endtask

  task automatic test_ack_race();
    run_miss(1'b1, $urandom, $urandom, $urandom, $urandom, T - 1, T - 1, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL ack_race err=%b required 0", err);
    end
  endtask

  task automatic test_spurious();
    logic [1:0] cnt0;
    cnt0 = miss_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      miss_req = 1'b0; wb_req = 1'b1; miss_addr = $urandom;
      mbus.mem_ack = 1'b1; mbus.mem_rdata = $urandom;
      @(negedge clk);
      mbus.mem_ack = 1'b0;
      checks++;
      if ({busy, mbus.mem_req, fill_valid, fill_err} !== 4'b0 || fill_data !== exp_fill ||
          miss_cnt !== cnt0) begin
        errors++;
        $display("FAIL idle_ack busy/req/fv/ferr=%b fill_data=%h miss_cnt=%0d required 0000 %h %0d",
                 {busy, mbus.mem_req, fill_valid, fill_err}, fill_data, miss_cnt, exp_fill, cnt0);
      end
    end
    run_miss(1'b1, $urandom, $urandom, $urandom, $urandom, 2, 1, 1'b1);
    run_miss(1'b0, $urandom, $urandom, $urandom, $urandom, 0, 3, 1'b1);
  endtask

  task automatic test_timeout();
    run_miss(1'b0, $urandom, $urandom, $urandom, $urandom, 0, 100, 1'b0);
    run_miss(1'b0, $urandom, $urandom, $urandom, $urandom, 0, 1, 1'b0);
    run_miss(1'b1, $urandom, $urandom, $urandom, $urandom, 100, 0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky err=%b required 1", err);
    end
  endtask

  task automatic test_reset_mid_wb();
    @(negedge clk);
    miss_req = 1'b1; wb_req = 1'b1; wb_addr = $urandom; wb_data = $urandom; miss_addr = $urandom;
    @(negedge clk);
    miss_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({fill_data, fill_valid, fill_err, busy, err, mbus.mem_req, mbus.mem_we,
         mbus.mem_addr, mbus.mem_wdata, miss_cnt, wb_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wb req=%b busy=%b err=%b we=%b addr=%h wdata=%h fill_data=%h cnt=%0d/%0d required all zero",
               mbus.mem_req, busy, err, mbus.mem_we, mbus.mem_addr, mbus.mem_wdata,
               fill_data, miss_cnt, wb_cnt);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run_miss(1'b0, $urandom, $urandom, $urandom, $urandom, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++)
      run_miss(1'($urandom), $urandom, $urandom, $urandom, $urandom, 0, 1, 1'b0);
    checks++;
    if (miss_cnt !== 2'd3 || miss_cnt_b !== 16'd5) begin
      errors++;
      $display("FAIL saturation miss_cnt=%0d wide=%0d required 3 5", miss_cnt, miss_cnt_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_miss(1'($urandom), $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
  endtask

  initial begin
    miss_req = 1'b0; wb_req = 1'b0; miss_addr = '0; wb_addr = '0; wb_data = '0;
    mbus.mem_ack = 1'b0; mbus.mem_rdata = '0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_ack_race();
    test_spurious();
    test_timeout();
    test_reset_mid_wb();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
